mul_div_issue_queue: RTL and testbench

MUL_DIV_ISSUE_QUEUE -- requirements
Module: mul_div_issue_queue

---
 rtl/mul_div_issue_queue.sv | 153 +++++++++++++++
 tb/tb_mul_div_issue_queue.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_issue_queue.sv
// mul_div_issue_queue
//
// In-order issue queue in front of the multiply/divide unit. Dispatch writes
// one instruction pair at the tail. Each entry keeps its four source tags and
// a ready bit for each tag. The entry at the head issues once all four of its
// registered ready bits are set. Younger entries never bypass the head.
//
// Ports
//   clk, resetn          rising-edge clock, asynchronous active-low reset
//   flush                synchronous flush; empties the queue at the next edge
//   dispatch_valid/ready enqueue handshake
//   dispatch_payload     opaque pair payload, returned unchanged at issue
//   dispatch_src_tag     4 source tags {HI/LO slots 3:2, operand B/A slots 1:0}
//   dispatch_src_rdy     per-slot readiness at dispatch
//   wakeup_valid/tag     two result-broadcast ports
//   issue_valid          head entry ready to go
//   mul_div_allowin      unit accepts the head this cycle
//   issue_payload/tag    head entry contents (all-zero while empty)
//   count                current occupancy, 0..DEPTH
module mul_div_issue_queue #(
  parameter int DEPTH     = 4,
  parameter int PAYLOAD_W = 64,
  parameter int TAG_W     = 6
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    flush,
  input  logic                    dispatch_valid,
  output logic                    dispatch_ready,
  input  logic [PAYLOAD_W-1:0]    dispatch_payload,
  input  logic [4*TAG_W-1:0]      dispatch_src_tag,
  input  logic [3:0]              dispatch_src_rdy,
  input  logic [1:0]              wakeup_valid,
  input  logic [2*TAG_W-1:0]      wakeup_tag,
  output logic                    issue_valid,
  input  logic                    mul_div_allowin,
  output logic [PAYLOAD_W-1:0]    issue_payload,
  output logic [4*TAG_W-1:0]      issue_src_tag,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PAYLOAD_W-1:0] payload_q [DEPTH];
  logic [4*TAG_W-1:0]   tag_q     [DEPTH];
  logic [3:0]           rdy_q     [DEPTH];
  logic [3:0]           rdy_d     [DEPTH];
  logic [DEPTH-1:0]     valid_q, valid_d;
  logic [PTR_W-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 enq, deq;
  logic [3:0]           enq_rdy;

  // True when either broadcast port carries tag t this cycle.
  function automatic logic wake_hit(input logic [TAG_W-1:0]   t,
                                    input logic [1:0]         wv,
                                    input logic [2*TAG_W-1:0] wt);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (wv[k] && (wt[k*TAG_W +: TAG_W] == t)) hit = 1'b1;
    end
    return hit;
  endfunction

  assign dispatch_ready = (count_q < CNT_W'(DEPTH)) && !flush;
  // Only registered ready bits count here, so a wakeup never bypasses into
  // issue in the cycle of its broadcast.
  assign issue_valid    = (count_q != '0) && (&rdy_q[head_q]) && !flush;
  assign enq            = dispatch_valid && dispatch_ready;
  assign deq            = issue_valid && mul_div_allowin;

  assign count          = count_q;
  assign issue_payload  = (count_q != '0) ? payload_q[head_q] : '0;
  assign issue_src_tag  = (count_q != '0) ? tag_q[head_q]     : '0;

  // Ready bits for a newly dispatched entry. Tag 0 is the hardwired-ready
  // register. A wakeup in the same cycle is caught here so it is not lost.
  always_comb begin
    enq_rdy = '0;
    for (int s = 0; s < 4; s++) begin
      enq_rdy[s] = dispatch_src_rdy[s]
                 | wake_hit(dispatch_src_tag[s*TAG_W +: TAG_W], wakeup_valid, wakeup_tag)
                 | (dispatch_src_tag[s*TAG_W +: TAG_W] == '0);
    end
  end

  // Next-state logic: wakeup, dequeue at head, enqueue at tail, then flush.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    for (int e = 0; e < DEPTH; e++) begin
      rdy_d[e] = rdy_q[e];
      if (valid_q[e]) begin
        for (int s = 0; s < 4; s++) begin
          if (wake_hit(tag_q[e][s*TAG_W +: TAG_W], wakeup_valid, wakeup_tag))
            rdy_d[e][s] = 1'b1;
        end
      end
    end
    if (deq) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + 1'b1;
    end
    if (enq) begin
      valid_d[tail_q] = 1'b1;
      rdy_d[tail_q]   = enq_rdy;
      tail_d          = tail_q + 1'b1;
    end
    unique case ({enq, deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // enq and deq are already blocked by flush; this only empties the queue.
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      valid_d = '0;
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      for (int e = 0; e < DEPTH; e++) rdy_q[e] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      for (int e = 0; e < DEPTH; e++) rdy_q[e] <= rdy_d[e];
    end
  end

  // Payload and tag storage has no reset. The outputs are masked while the
  // queue is empty.
  always_ff @(posedge clk) begin
    if (enq) begin
      payload_q[tail_q] <= dispatch_payload;
      tag_q[tail_q]     <= dispatch_src_tag;
    end
  end

endmodule

// File: tb/tb_mul_div_issue_queue.sv
// Testbench for mul_div_issue_queue (default parameters).
// The table rows give, for each cycle, the inputs and the expected occupancy
// and handshake outputs. A scoreboard checks the issued payload and tags.
module tb_mul_div_issue_queue;

  logic        clk;
  logic        resetn;
  logic        flush;
  logic        dispatchValid;
  logic        dispatchReady;
  logic [63:0] dispatchPayload;
  logic [23:0] dispatchSrcTag;
  logic [3:0]  dispatchSrcRdy;
  logic [1:0]  wakeupValid;
  logic [11:0] wakeupTag;
  logic        issueValid;
  logic        mulDivAllowin;
  logic [63:0] issuePayload;
  logic [23:0] issueSrcTag;
  logic [2:0]  count;

  typedef struct {
    logic        dv;
    logic [63:0] pl;
    logic [23:0] tags;
    logic [3:0]  rdy;
    logic [1:0]  wv;
    logic [11:0] wt;
    logic        allow;
    logic        fl;
    int          expCount;
    logic        expIssueValid;
    logic        expDispatchReady;
  } vec_t;

  typedef struct {
    logic [63:0] pl;
    logic [23:0] tags;
  } sbEntry_t;

  sbEntry_t sbq[$];
  vec_t     vecs[$];
  int       nChecks = 0;
  int       nErrors = 0;

  mul_div_issue_queue dut (
    .clk              (clk),
    .resetn           (resetn),
    .flush            (flush),
    .dispatch_valid   (dispatchValid),
    .dispatch_ready   (dispatchReady),
    .dispatch_payload (dispatchPayload),
    .dispatch_src_tag (dispatchSrcTag),
    .dispatch_src_rdy (dispatchSrcRdy),
    .wakeup_valid     (wakeupValid),
    .wakeup_tag       (wakeupTag),
    .issue_valid      (issueValid),
    .mul_div_allowin  (mulDivAllowin),
    .issue_payload    (issuePayload),
    .issue_src_tag    (issueSrcTag),
    .count            (count)
  );

  // Free-running clock with a 10 ns period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Packs tags for slots 0..3 into the dispatch bus layout.
  function automatic logic [23:0] tg(input logic [5:0] a, input logic [5:0] b,
                                     input logic [5:0] c, input logic [5:0] d);
    return {d, c, b, a};
  endfunction

  function automatic vec_t mk(input logic dv, input logic [63:0] pl,
                              input logic [23:0] tags, input logic [3:0] rdy,
                              input logic [1:0] wv, input logic [11:0] wt,
                              input logic allow, input logic fl, input int ec,
                              input logic eiv, input logic edr);
    vec_t v;
    v.dv = dv; v.pl = pl; v.tags = tags; v.rdy = rdy; v.wv = wv; v.wt = wt;
    v.allow = allow; v.fl = fl; v.expCount = ec;
    v.expIssueValid = eiv; v.expDispatchReady = edr;
    return v;
  endfunction

  // Records one comparison and prints a FAIL line on a mismatch.
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives one row's inputs just after a rising edge.
  task automatic applyStimulus(input vec_t v);
    dispatchValid   = v.dv;
    dispatchPayload = v.pl;
    dispatchSrcTag  = v.tags;
    dispatchSrcRdy  = v.rdy;
    wakeupValid     = v.wv;
    wakeupTag       = v.wt;
    mulDivAllowin   = v.allow;
    flush           = v.fl;
  endtask

  // Samples on the falling edge. Checks the handshake against the row and
  // updates the scoreboard from the row's expectations, not from the DUT.
  task automatic checkOutput(input vec_t v, input string name);
    sbEntry_t e;
    @(negedge clk);
    chk({name, " count"}, 128'(count), 128'(v.expCount));
    chk({name, " issue_valid"}, 128'(issueValid), 128'(v.expIssueValid));
    chk({name, " dispatch_ready"}, 128'(dispatchReady), 128'(v.expDispatchReady));
    if (v.expCount == 0) begin
      chk({name, " empty payload"}, 128'(issuePayload), 128'(0));
      chk({name, " empty tags"}, 128'(issueSrcTag), 128'(0));
    end
    if (v.expIssueValid && v.allow) begin
      if (sbq.size() == 0) begin
        chk({name, " scoreboard underflow"}, 128'(1), 128'(0));
      end else begin
        e = sbq.pop_front();
        chk({name, " issue payload"}, 128'(issuePayload), 128'(e.pl));
        chk({name, " issue tags"}, 128'(issueSrcTag), 128'(e.tags));
      end
    end
    if (v.dv && v.expDispatchReady && !v.fl) begin
      e.pl   = v.pl;
      e.tags = v.tags;
      sbq.push_back(e);
    end
    if (v.fl) sbq.delete();
  endtask

  task automatic runVector(input vec_t v, input string name);
    applyStimulus(v);
    checkOutput(v, name);
    @(posedge clk);
    #1;
  endtask

  // Main sequence: reset, table rows, then hand-written corner cases.
  initial begin
    resetn = 1'b0;
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    #12;
    chk("reset count", 128'(count), 128'(0));
    chk("reset issue_valid", 128'(issueValid), 128'(0));
    chk("reset payload", 128'(issuePayload), 128'(0));
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // Single pair fully ready.
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1));
    vecs.push_back(mk(1, 64'hA000_0000_0000_0001, tg(1,2,3,4), 4'b1111, 0, 0, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1));
    // Slot 1 waits on tag 5. The wakeup in row 6 does not issue until row 7.
    vecs.push_back(mk(1, 64'hA000_0000_0000_0002, tg(1,5,3,4), 4'b1101, 0, 0, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 2'b01, 12'd5, 1, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1));
    // Tag 9 is woken in the dispatch cycle on port 1. Then the head is held.
    vecs.push_back(mk(1, 64'hA000_0000_0000_0003, tg(9,2,3,4), 4'b1110, 2'b10, 12'h240, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1));
    // Fill the queue, then stream through it with wraparound.
    vecs.push_back(mk(1, 64'hB4, tg(4,5,6,7), 4'b1111, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 64'hB5, tg(5,6,7,8), 4'b1111, 0, 0, 0, 0, 1, 1, 1));
    vecs.push_back(mk(1, 64'hB6, tg(6,7,8,9), 4'b1111, 0, 0, 0, 0, 2, 1, 1));
    vecs.push_back(mk(1, 64'hB7, tg(7,8,9,10), 4'b1111, 0, 0, 0, 0, 3, 1, 1));
    vecs.push_back(mk(1, 64'hB8, tg(8,9,10,11), 4'b1111, 0, 0, 0, 0, 4, 1, 0));
    vecs.push_back(mk(1, 64'hB8, tg(8,9,10,11), 4'b1111, 0, 0, 1, 0, 4, 1, 0));
    vecs.push_back(mk(1, 64'hB8, tg(8,9,10,11), 4'b1111, 0, 0, 1, 0, 3, 1, 1));
    vecs.push_back(mk(1, 64'hB9, tg(9,10,11,12), 4'b1111, 0, 0, 1, 0, 3, 1, 1));
    vecs.push_back(mk(1, 64'hBA, tg(10,11,12,13), 4'b1111, 0, 0, 1, 0, 3, 1, 1));
    vecs.push_back(mk(1, 64'hBB, tg(11,12,13,14), 4'b1111, 0, 0, 1, 0, 3, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 3, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 2, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      runVector(vecs[i], $sformatf("row%0d", i));
    end

    // An unready head blocks a ready younger entry until tag 22 wakes it.
    runVector(mk(1, 64'hC1, tg(20,21,22,23), 4'b1011, 0, 0, 1, 0, 0, 0, 1), "hol0");
    runVector(mk(1, 64'hC2, tg(1,2,3,4), 4'b1111, 0, 0, 1, 0, 1, 0, 1), "hol1");
    runVector(mk(0, 0, 0, 0, 0, 0, 1, 0, 2, 0, 1), "hol2");
    runVector(mk(0, 0, 0, 0, 2'b01, 12'd22, 1, 0, 2, 0, 1), "hol3");
    runVector(mk(0, 0, 0, 0, 0, 0, 1, 0, 2, 1, 1), "hol4");
    runVector(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 1), "hol5");
    runVector(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1), "hol6");
    // Tag 0 counts as ready even when dispatch marks it unready.
    runVector(mk(1, 64'hC3, tg(0,2,3,4), 4'b1110, 0, 0, 1, 0, 0, 0, 1), "tag0a");
    runVector(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 1), "tag0b");
    runVector(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1), "tag0c");

    // Flush with three entries while a dispatch is offered.
    runVector(mk(1, 64'hD1, tg(1,2,3,4), 4'b1111, 0, 0, 0, 0, 0, 0, 1), "fl0");
    runVector(mk(1, 64'hD2, tg(1,2,3,4), 4'b1111, 0, 0, 0, 0, 1, 1, 1), "fl1");
    runVector(mk(1, 64'hD3, tg(1,2,3,4), 4'b1111, 0, 0, 0, 0, 2, 1, 1), "fl2");
    runVector(mk(1, 64'hD4, tg(1,2,3,4), 4'b1111, 0, 0, 1, 1, 3, 0, 0), "fl3");
    runVector(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1), "fl4");

    // Asynchronous reset pulse in the middle of a fill.
    runVector(mk(1, 64'hE1, tg(1,2,3,4), 4'b1111, 0, 0, 0, 0, 0, 0, 1), "rst0");
    runVector(mk(1, 64'hE2, tg(1,2,3,4), 4'b1111, 0, 0, 0, 0, 1, 1, 1), "rst1");
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1));
    resetn = 1'b0;
    #1;
    chk("rst async count", 128'(count), 128'(0));
    chk("rst async issue_valid", 128'(issueValid), 128'(0));
    #2;
    resetn = 1'b1;
    sbq.delete();
    runVector(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1), "rst2");
    runVector(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1), "rst3");

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
